// File: rtl/chaos_pkg.sv
// chaos_pkg: shared width default and collector FSM state encoding.
package chaos_pkg;
  localparam int CHAOS_OVLD_W_DEFAULT = 32;
  typedef enum logic [1:0] {IDLE, SEED, WAIT, DRAIN} state_t;
endpackage

// File: rtl/chaos_sync_fifo.sv
// chaos_sync_fifo: per-channel result buffer with a registered head, so a push is visible one cycle later.
module chaos_sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic wr, rd;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) mem[wp] <= din;
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/chaos_pair_collector.sv
// chaos_pair_collector: seeds the theta/z generators, feeds results back for ROUNDS rounds
// and emits the buffered results downstream as round-aligned (theta, z) pairs.
module chaos_pair_collector import chaos_pkg::*; #(
  parameter int CHAOS_OVLD_W = CHAOS_OVLD_W_DEFAULT,
  parameter int ROUNDS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CHAOS_OVLD_W-1:0] seed_theta,
  input  logic [CHAOS_OVLD_W-1:0] seed_z,
  output logic                    busy,
  output logic                    done,
  output logic [CHAOS_OVLD_W-1:0] theta_x0,
  output logic                    theta_x0_vld,
  input  logic                    theta_x0_rdy,
  input  logic [CHAOS_OVLD_W-1:0] theta_xout,
  input  logic                    theta_xout_vld,
  output logic                    theta_xout_rdy,
  output logic [CHAOS_OVLD_W-1:0] z_x0,
  output logic                    z_x0_vld,
  input  logic                    z_x0_rdy,
  input  logic [CHAOS_OVLD_W-1:0] z_xout,
  input  logic                    z_xout_vld,
  output logic                    z_xout_rdy,
  output logic [CHAOS_OVLD_W-1:0] pair_theta,
  output logic [CHAOS_OVLD_W-1:0] pair_z,
  output logic                    pair_vld,
  input  logic                    pair_rdy,
  output logic                    pair_last
);
  localparam int W = CHAOS_OVLD_W;
  localparam int CW = $clog2(ROUNDS + 1);
  state_t state, state_n;
  logic [W-1:0] theta_seed, z_seed;
  logic [CW-1:0] issue_cnt, out_cnt;
  logic hs_theta, hs_z;
  logic x0_t, x0_z, push_t, push_z, pop, seed_done, round_done;
  logic full_t, full_z, empty_t, empty_z;
  assign theta_x0 = theta_seed;
  assign z_x0 = z_seed;
  assign x0_t = theta_x0_vld && theta_x0_rdy;
  assign x0_z = z_x0_vld && z_x0_rdy;
  assign push_t = theta_xout_vld && theta_xout_rdy;
  assign push_z = z_xout_vld && z_xout_rdy;
  assign pop = pair_vld && pair_rdy;
  assign seed_done = (hs_theta || x0_t) && (hs_z || x0_z);
  assign round_done = (hs_theta || push_t) && (hs_z || push_z);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? SEED : IDLE;
      SEED:    state_n = seed_done ? WAIT : SEED;
      WAIT:    state_n = !round_done ? WAIT : (issue_cnt + CW'(1) < CW'(ROUNDS)) ? SEED : DRAIN;
      DRAIN:   state_n = done ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // hs_* means "x0 sent" in SEED and "xout got" in WAIT; cleared on every state change
  always_comb begin
    busy = state != IDLE;
    theta_x0_vld = state == SEED && !hs_theta;
    z_x0_vld = state == SEED && !hs_z;
    theta_xout_rdy = state == WAIT && !full_t && !hs_theta;
    z_xout_rdy = state == WAIT && !full_z && !hs_z;
    pair_vld = busy && !empty_t && !empty_z;
    pair_last = pair_vld && out_cnt == CW'(ROUNDS - 1);
    done = state == DRAIN && pop && pair_last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_seed <= '0;
      z_seed <= '0;
      issue_cnt <= '0;
      out_cnt <= '0;
      hs_theta <= 1'b0;
      hs_z <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        theta_seed <= seed_theta;
        z_seed <= seed_z;
        issue_cnt <= '0;
        out_cnt <= '0;
      end else begin
        if (push_t) theta_seed <= theta_xout;
        if (push_z) z_seed <= z_xout;
        if (state == WAIT && round_done) issue_cnt <= issue_cnt + CW'(1);
        if (pop) out_cnt <= out_cnt + CW'(1);
      end
      hs_theta <= state != state_n ? 1'b0 : hs_theta || x0_t || push_t;
      hs_z <= state != state_n ? 1'b0 : hs_z || x0_z || push_z;
    end
  end
  chaos_sync_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_theta_fifo (
    .clk(clk), .rst(rst), .push(push_t), .din(theta_xout), .pop(pop),
    .dout(pair_theta), .full(full_t), .empty(empty_t)
  );
  chaos_sync_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_z_fifo (
    .clk(clk), .rst(rst), .push(push_z), .din(z_xout), .pop(pop),
    .dout(pair_z), .full(full_z), .empty(empty_z)
  );
endmodule

// File: tb/tb_chaos_pair_collector.sv
// tb_chaos_pair_collector: generator models around the collector, scoreboard of expected pairs.
module tb_chaos_pair_collector;
  localparam int R = 4;
  localparam logic [31:0] KT = 32'h0001_0000;
  localparam logic [31:0] KZ = 32'h0002_0000;
  typedef struct {
    logic [31:0] st, sz;
    int lt, lz, stall;
    bit restart;
    logic [31:0] last_t, last_z;
  } vec_t;
  typedef struct { logic [31:0] t, z; logic last; } exp_t;
  typedef struct { bit busy; bit vld; int cnt; int nxo; logic [31:0] res, exp_seed; } gen_t;
  logic clk = 1'b0, rst;
  logic start, busy, done, pair_vld, pair_rdy, pair_last;
  logic [31:0] seed_theta, seed_z, pair_theta, pair_z;
  logic [31:0] theta_x0, theta_xout, z_x0, z_xout;
  logic theta_x0_vld, theta_x0_rdy, theta_xout_vld, theta_xout_rdy;
  logic z_x0_vld, z_x0_rdy, z_xout_vld, z_xout_rdy;
  logic s_start, s_busy, s_done, s_pair_vld, s_pair_rdy, s_pair_last;
  logic [31:0] s_seed_theta, s_seed_z, s_pair_theta, s_pair_z;
  logic [31:0] s_theta_x0, s_theta_xout, s_z_x0, s_z_xout;
  logic s_theta_x0_vld, s_theta_x0_rdy, s_theta_xout_vld, s_theta_xout_rdy;
  logic s_z_x0_vld, s_z_x0_rdy, s_z_xout_vld, s_z_xout_rdy;
  int total = 0, passed = 0, done_cnt, pairs, lat_t, lat_z;
  logic [31:0] last_t, last_z;
  exp_t sb[$];
  gen_t gt, gz;
  vec_t vecs[5];

  always #5 clk = ~clk;

  chaos_pair_collector #(.CHAOS_OVLD_W(32), .ROUNDS(R), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_theta(seed_theta), .seed_z(seed_z),
    .busy(busy), .done(done),
    .theta_x0(theta_x0), .theta_x0_vld(theta_x0_vld), .theta_x0_rdy(theta_x0_rdy),
    .theta_xout(theta_xout), .theta_xout_vld(theta_xout_vld), .theta_xout_rdy(theta_xout_rdy),
    .z_x0(z_x0), .z_x0_vld(z_x0_vld), .z_x0_rdy(z_x0_rdy),
    .z_xout(z_xout), .z_xout_vld(z_xout_vld), .z_xout_rdy(z_xout_rdy),
    .pair_theta(pair_theta), .pair_z(pair_z), .pair_vld(pair_vld), .pair_rdy(pair_rdy),
    .pair_last(pair_last)
  );

  chaos_pair_collector #(.CHAOS_OVLD_W(32), .ROUNDS(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .start(s_start), .seed_theta(s_seed_theta), .seed_z(s_seed_z),
    .busy(s_busy), .done(s_done),
    .theta_x0(s_theta_x0), .theta_x0_vld(s_theta_x0_vld), .theta_x0_rdy(s_theta_x0_rdy),
    .theta_xout(s_theta_xout), .theta_xout_vld(s_theta_xout_vld), .theta_xout_rdy(s_theta_xout_rdy),
    .z_x0(s_z_x0), .z_x0_vld(s_z_x0_vld), .z_x0_rdy(s_z_x0_rdy),
    .z_xout(s_z_xout), .z_xout_vld(s_z_xout_vld), .z_xout_rdy(s_z_xout_rdy),
    .pair_theta(s_pair_theta), .pair_z(s_pair_z), .pair_vld(s_pair_vld), .pair_rdy(s_pair_rdy),
    .pair_last(s_pair_last)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h, expected %h", n, a, e);
  endtask

  task automatic drive_gens();
    theta_x0_rdy = !gt.busy;
    theta_xout_vld = gt.vld;
    theta_xout = gt.res;
    z_x0_rdy = !gz.busy;
    z_xout_vld = gz.vld;
    z_xout = gz.res;
  endtask

  task automatic reset_model();
    gt = '{default: 0};
    gz = '{default: 0};
    sb.delete();
    pair_rdy = 1'b1;
    drive_gens();
  endtask

  // generator: accept x0, return x0+k after lat cycles, hold xout until taken
  task automatic gen_step(input logic acc, input logic [31:0] x0, input logic ret, input int lat,
                          input logic [31:0] k, input string nm, inout gen_t g);
    if (ret) begin
      g.vld = 0;
      g.busy = 0;
      g.exp_seed = g.res;
      g.nxo++;
    end
    if (acc) begin
      chk(nm, x0, g.exp_seed);
      g.busy = 1;
      g.cnt = lat;
      g.res = x0 + k;
    end else if (g.busy && !g.vld) begin
      g.cnt--;
      if (g.cnt <= 0) g.vld = 1;
    end
  endtask

  task automatic tick();
    logic tx, zx, tr, zr, pv, pl, dn;
    logic [31:0] tx0, zx0, pt, pz;
    exp_t e;
    #1;
    tx = theta_x0_vld & theta_x0_rdy;
    zx = z_x0_vld & z_x0_rdy;
    tr = theta_xout_vld & theta_xout_rdy;
    zr = z_xout_vld & z_xout_rdy;
    pv = pair_vld & pair_rdy;
    tx0 = theta_x0;
    zx0 = z_x0;
    pt = pair_theta;
    pz = pair_z;
    pl = pair_last;
    dn = done;
    @(posedge clk);
    #1;
    if (rst) return;
    if (dn) done_cnt++;
    if (pv) begin
      pairs++;
      last_t = pt;
      last_z = pz;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL pair_extra: got %h/%h, expected no pair", pt, pz);
      end else begin
        e = sb.pop_front();
        chk("pair_theta", pt, e.t);
        chk("pair_z", pz, e.z);
        chk("pair_last", {31'b0, pl}, {31'b0, e.last});
      end
    end
    gen_step(tx, tx0, tr, lat_t, KT, "seed_theta", gt);
    gen_step(zx, zx0, zr, lat_z, KZ, "seed_z", gz);
    drive_gens();
  endtask

  task automatic launch(input vec_t v);
    logic [31:0] t, z;
    lat_t = v.lt;
    lat_z = v.lz;
    gt.exp_seed = v.st;
    gz.exp_seed = v.sz;
    gt.nxo = 0;
    gz.nxo = 0;
    pairs = 0;
    done_cnt = 0;
    seed_theta = v.st;
    seed_z = v.sz;
    t = v.st;
    z = v.sz;
    for (int r = 0; r < R; r++) begin
      t = t + KT;
      z = z + KZ;
      sb.push_back('{t, z, r == R - 1});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    launch(v);
    pair_rdy = v.stall == 0;
    for (int c = 0; c < 1000 && done_cnt == 0; c++) begin
      if (v.restart && (c == 2 || c == 7)) begin
        start = 1'b1;
        seed_theta = 32'hDEAD_BEEF;
        seed_z = 32'hCAFE_F00D;
      end else start = 1'b0;
      if (v.stall != 0 && c == v.stall) begin
        chk("stall_nxo_theta", gt.nxo, 32'd2);
        chk("stall_nxo_z", gz.nxo, 32'd2);
        chk("stall_rdy_theta", {31'b0, theta_xout_rdy}, 32'd0);
        chk("stall_rdy_z", {31'b0, z_xout_rdy}, 32'd0);
        pair_rdy = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    chk("done_count", done_cnt, 32'd1);
    chk("pair_count", pairs, R);
    chk("busy_end", {31'b0, busy}, 32'd0);
    chk("last_theta", last_t, v.last_t);
    chk("last_z", last_z, v.last_z);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 32'h0000_5678, 3, 3, 0, 0, 32'h0004_1234, 32'h0008_5678};
    vecs[1] = '{32'h0000_1234, 32'h0000_5678, 13, 3, 0, 0, 32'h0004_1234, 32'h0008_5678};
    vecs[2] = '{32'h0000_1234, 32'h0000_5678, 3, 13, 0, 0, 32'h0004_1234, 32'h0008_5678};
    vecs[3] = '{32'h0000_1234, 32'h0000_5678, 3, 3, 40, 0, 32'h0004_1234, 32'h0008_5678};
    vecs[4] = '{32'h0000_0001, 32'h0000_0002, 3, 3, 0, 1, 32'h0004_0001, 32'h0008_0002};
    rst = 1'b1;
    start = 1'b0;
    seed_theta = '0;
    seed_z = '0;
    lat_t = 3;
    lat_z = 3;
    done_cnt = 0;
    pairs = 0;
    s_start = 1'b0;
    s_seed_theta = '0;
    s_seed_z = '0;
    s_theta_x0_rdy = 1'b1;
    s_z_x0_rdy = 1'b1;
    s_theta_xout = '0;
    s_z_xout = '0;
    s_theta_xout_vld = 1'b0;
    s_z_xout_vld = 1'b0;
    s_pair_rdy = 1'b1;
    reset_model();
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_x0_vld", {30'b0, theta_x0_vld, z_x0_vld}, 32'd0);
    chk("rst_xout_rdy", {30'b0, theta_xout_rdy, z_xout_rdy}, 32'd0);
    chk("rst_pair", {30'b0, pair_vld, pair_last}, 32'd0);
    chk("rst_theta_x0", theta_x0, 32'd0);
    chk("rst_pair_theta", pair_theta, 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) run_frame(vecs[i]);
    // abandon a frame while WAIT holds one theta result and z is still outstanding
    launch('{32'h0000_1234, 32'h0000_5678, 3, 13, 0, 0, 32'h0, 32'h0});
    for (int c = 0; c < 100 && gt.nxo == 0; c++) tick();
    tick();
    chk("t5_theta_got", gt.nxo, 32'd1);
    chk("t5_z_pending", gz.nxo, 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_x0_vld", {30'b0, theta_x0_vld, z_x0_vld}, 32'd0);
    chk("t5_xout_rdy", {30'b0, theta_xout_rdy, z_xout_rdy}, 32'd0);
    chk("t5_pair_vld", {31'b0, pair_vld}, 32'd0);
    reset_model();
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_frame(vecs[0]);
    // single-round frame on the ROUNDS=1 instance, both results in the same cycle
    s_seed_theta = 32'hAAAA_0000;
    s_seed_z = 32'h5555_0000;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("t6_busy", {31'b0, s_busy}, 32'd1);
    chk("t6_x0_vld", {30'b0, s_theta_x0_vld, s_z_x0_vld}, 32'd3);
    chk("t6_theta_x0", s_theta_x0, 32'hAAAA_0000);
    chk("t6_z_x0", s_z_x0, 32'h5555_0000);
    tick();
    chk("t6_wait_x0_vld", {30'b0, s_theta_x0_vld, s_z_x0_vld}, 32'd0);
    chk("t6_wait_rdy", {30'b0, s_theta_xout_rdy, s_z_xout_rdy}, 32'd3);
    s_theta_xout = 32'h1357_9BDF;
    s_z_xout = 32'h2468_ACE0;
    s_theta_xout_vld = 1'b1;
    s_z_xout_vld = 1'b1;
    tick();
    s_theta_xout_vld = 1'b0;
    s_z_xout_vld = 1'b0;
    chk("t6_drain_rdy", {30'b0, s_theta_xout_rdy, s_z_xout_rdy}, 32'd0);
    chk("t6_pair_vld", {31'b0, s_pair_vld}, 32'd1);
    chk("t6_pair_theta", s_pair_theta, 32'h1357_9BDF);
    chk("t6_pair_z", s_pair_z, 32'h2468_ACE0);
    chk("t6_pair_last", {31'b0, s_pair_last}, 32'd1);
    chk("t6_done", {31'b0, s_done}, 32'd1);
    tick();
    chk("t6_done_after", {31'b0, s_done}, 32'd0);
    chk("t6_busy_after", {31'b0, s_busy}, 32'd0);
    chk("t6_pair_vld_after", {31'b0, s_pair_vld}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
